// File: rtl/debounced_not_bank.sv
// debounced_not_bank
//   Bank of WIDTH independent input channels sitting between raw board inputs
//   and user logic. Each channel is synchronised to clk, debounced by a small
//   per-channel counter FSM, then passed through a runtime-selectable inverter.
//   Single-cycle rise/fall pulses report accepted level changes on the input
//   side. Inversion never produces a pulse.
//
//   Ports:
//     clk      system clock, rising edge
//     rst_n    asynchronous active-low reset
//     din      raw asynchronous channel inputs          [WIDTH]
//     inv      per-channel invert select (1 = NOT)      [WIDTH]
//     dout     registered debounced (optionally inverted) level [WIDTH]
//     in_rise  one-cycle pulse on an accepted 0->1      [WIDTH]
//     in_fall  one-cycle pulse on an accepted 1->0      [WIDTH]
//     busy     high while any channel is COUNTING
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_STABLE   | sampled input equals accepted level, counter held at 0
//   ST_COUNTING | sampled input differs, counting consecutive differing samples
module debounced_not_bank #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] inv,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] in_rise,
    output logic [WIDTH-1:0] in_fall,
    output logic             busy
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    // The leading flop captures the pad, followed by SYNC_STAGES synchroniser
    // flops. A step just before edge 1 is therefore first compared on edge
    // SYNC_STAGES+2 and accepted on edge SYNC_STAGES+DEBOUNCE+1.
    localparam int              CHAIN    = SYNC_STAGES + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [WIDTH-1:0] r_sync [CHAIN];
    state_t           r_state [WIDTH];
    state_t           w_state_nxt [WIDTH];
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0] r_st;
    logic [WIDTH-1:0] w_st_nxt;
    logic [WIDTH-1:0] w_commit;
    logic [WIDTH-1:0] w_s;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_busy;

    assign w_s = r_sync[CHAIN-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CHAIN; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= din;
            for (int k = 1; k < CHAIN; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    always_comb begin
        w_st_nxt   = r_st;
        w_commit   = '0;
        w_busy_nxt = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_cnt_nxt[i]   = r_cnt[i];
            case (r_state[i])
                ST_STABLE: begin
                    if (w_s[i] == r_st[i]) begin
                        w_cnt_nxt[i] = '0;
                    end else if (DEBOUNCE == 1) begin
                        // A single differing sample is enough: accept at once.
                        w_st_nxt[i]  = w_s[i];
                        w_commit[i]  = 1'b1;
                        w_cnt_nxt[i] = '0;
                    end else begin
                        w_cnt_nxt[i]   = CNT_W'(1);
                        w_state_nxt[i] = ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (w_s[i] == r_st[i]) begin
                        // Bounce: drop the partial count so the next attempt
                        // needs a full window again.
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_STABLE;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_st_nxt[i]    = w_s[i];
                        w_commit[i]    = 1'b1;
                        w_cnt_nxt[i]   = '0;
                        w_state_nxt[i] = ST_STABLE;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    w_cnt_nxt[i]   = '0;
                    w_state_nxt[i] = ST_STABLE;
                end
            endcase
            if (w_state_nxt[i] == ST_COUNTING) begin
                w_busy_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= ST_STABLE;
                r_cnt[i]   <= '0;
            end
            r_st <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_cnt[i]   <= w_cnt_nxt[i];
            end
            r_st <= w_st_nxt;
        end
    end

    // Events are taken from the input side; inv only affects dout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_busy <= 1'b0;
        end else begin
            r_dout <= w_st_nxt ^ inv;
            r_rise <= w_commit & w_s;
            r_fall <= w_commit & ~w_s;
            r_busy <= w_busy_nxt;
        end
    end

    assign dout    = r_dout;
    assign in_rise = r_rise;
    assign in_fall = r_fall;
    assign busy    = r_busy;

endmodule

// File: tb/tb_debounced_not_bank.sv
module tb_debounced_not_bank;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic [3:0] inv;
    logic [3:0] dout;
    logic [3:0] in_rise;
    logic [3:0] in_fall;
    logic       busy;

    logic       din_c;
    logic       inv_c;
    logic       dout_c;
    logic       rise_c;
    logic       fall_c;
    logic       busy_c;

    int n_pass  = 0;
    int n_total = 0;

    // Expected {dout, in_rise, in_fall, busy} per edge, pushed with stimulus.
    logic [12:0] exp_q [$];
    logic [3:0]  expc_q [$];

    logic [12:0] obs;
    logic [3:0]  obs_c;
    assign obs   = {dout, in_rise, in_fall, busy};
    assign obs_c = {dout_c, rise_c, fall_c, busy_c};

    always #5 clk = ~clk;

    debounced_not_bank u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din),
        .inv     (inv),
        .dout    (dout),
        .in_rise (in_rise),
        .in_fall (in_fall),
        .busy    (busy)
    );

    debounced_not_bank #(
        .WIDTH       (1),
        .SYNC_STAGES (3),
        .DEBOUNCE    (1),
        .CNT_W       (16)
    ) u_corner (
        .clk     (clk),
        .rst_n   (rst_n),
        .din     (din_c),
        .inv     (inv_c),
        .dout    (dout_c),
        .in_rise (rise_c),
        .in_fall (fall_c),
        .busy    (busy_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [12:0] pk(input logic [3:0] d, input logic [3:0] r,
                                       input logic [3:0] f, input logic b);
        return {d, r, f, b};
    endfunction

    // Expected trace for a clean step driven just before edge 1 with default
    // parameters: busy on edges 4..6, accept and pulse on edge 7.
    task automatic push_step(input int n, input logic [3:0] d_old, input logic [3:0] d_new,
                             input logic [3:0] r, input logic [3:0] f);
        for (int e = 1; e <= n; e++) begin
            exp_q.push_back(pk((e >= 7) ? d_new : d_old,
                               (e == 7) ? r : 4'h0,
                               (e == 7) ? f : 4'h0,
                               (e >= 4 && e <= 6)));
        end
    endtask

    task automatic test_reset();
        logic [12:0] e_exp;
        rst_n = 1'b0;
        din   = 4'h0;
        inv   = 4'h0;
        din_c = 1'b0;
        inv_c = 1'b0;
        tick();
        tick();
        n_total++;
        if (obs !== 13'h0) $display("FAIL reset_state: got %b expected %b", obs, 13'h0);
        else n_pass++;
        n_total++;
        if (obs_c !== 4'h0) $display("FAIL reset_state_corner: got %b expected %b", obs_c, 4'h0);
        else n_pass++;

        rst_n = 1'b1;
        inv   = 4'hF;
        for (int e = 1; e <= 3; e++) exp_q.push_back(pk(4'hF, 4'h0, 4'h0, 1'b0));
        for (int e = 1; e <= 3; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL reset_release edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end

        // Start a count on channel 0, then reset in the middle of it.
        din = 4'h1;
        push_step(4, 4'hF, 4'hF, 4'h0, 4'h0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL reset_midcount edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (obs !== 13'h0) $display("FAIL reset_async: got %b expected %b", obs, 13'h0);
        else n_pass++;
        din = 4'h0;
        #2;
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) exp_q.push_back(pk(4'hF, 4'h0, 4'h0, 1'b0));
        for (int e = 1; e <= 4; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL reset_rerelease edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_clean_step();
        logic [12:0] e_exp;
        din = 4'h1;
        push_step(10, 4'hF, 4'hE, 4'h1, 4'h0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL clean_rise edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
        din = 4'h0;
        push_step(10, 4'hE, 4'hF, 4'h0, 4'h1);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL clean_fall edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_bounce();
        logic [12:0] e_exp;
        // Three high samples reach the counter, one short of acceptance.
        din = 4'h2;
        for (int e = 1; e <= 10; e++) exp_q.push_back(pk(4'hF, 4'h0, 4'h0, (e >= 4 && e <= 6)));
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL bounce edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
            if (e == 3) din = 4'h0;
        end

        // Ten-cycle clean pulse must take a full window each way.
        din = 4'h2;
        for (int e = 1; e <= 20; e++) begin
            exp_q.push_back(pk((e >= 7 && e < 17) ? 4'hD : 4'hF,
                               (e == 7)  ? 4'h2 : 4'h0,
                               (e == 17) ? 4'h2 : 4'h0,
                               (e >= 4 && e <= 6) || (e >= 14 && e <= 16)));
        end
        for (int e = 1; e <= 20; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL after_bounce edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
            if (e == 10) din = 4'h0;
        end
    endtask

    task automatic test_invert();
        logic [12:0] e_exp;
        inv = 4'hB;
        for (int e = 1; e <= 3; e++) exp_q.push_back(pk(4'hB, 4'h0, 4'h0, 1'b0));
        for (int e = 1; e <= 3; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL invert_on edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
        inv = 4'hF;
        for (int e = 1; e <= 2; e++) exp_q.push_back(pk(4'hF, 4'h0, 4'h0, 1'b0));
        for (int e = 1; e <= 2; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL invert_off edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_multi();
        logic [12:0] e_exp;
        din = 4'hA;
        push_step(10, 4'hF, 4'h5, 4'hA, 4'h0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL multi_rise edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
        din = 4'h0;
        push_step(10, 4'h5, 4'hF, 4'h0, 4'hA);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL multi_fall edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_independence();
        logic [12:0] e_exp;
        // Channel 3 bounces (two samples) while channel 0 steps cleanly.
        din = 4'h9;
        push_step(10, 4'hF, 4'hE, 4'h1, 4'h0);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL independence edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
            if (e == 2) din = 4'h1;
        end
        din = 4'h0;
        push_step(10, 4'hE, 4'hF, 4'h0, 4'h1);
        for (int e = 1; e <= 10; e++) begin
            tick();
            e_exp = exp_q.pop_front();
            n_total++;
            if (obs !== e_exp) $display("FAIL independence_fall edge %0d: got %b expected %b", e, obs, e_exp);
            else n_pass++;
        end
    endtask

    task automatic test_corner();
        logic [3:0] e_exp;
        din_c = 1'b1;
        for (int e = 1; e <= 8; e++) expc_q.push_back((e < 5) ? 4'b0000 : (e == 5) ? 4'b1100 : 4'b1000);
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_exp = expc_q.pop_front();
            n_total++;
            if (obs_c !== e_exp) $display("FAIL corner_rise edge %0d: got %b expected %b", e, obs_c, e_exp);
            else n_pass++;
        end
        din_c = 1'b0;
        for (int e = 1; e <= 8; e++) expc_q.push_back((e < 5) ? 4'b1000 : (e == 5) ? 4'b0010 : 4'b0000);
        for (int e = 1; e <= 8; e++) begin
            tick();
            e_exp = expc_q.pop_front();
            n_total++;
            if (obs_c !== e_exp) $display("FAIL corner_fall edge %0d: got %b expected %b", e, obs_c, e_exp);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_invert();
        test_multi();
        test_independence();
        test_corner();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
